// File: rtl/store_drain_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_unit_pkg
// Description : Shared memory-interface types and the write-buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package store_drain_unit_pkg;

    localparam int C_ADDR_W    = 32;
    localparam int C_BLOCK_W   = 64;
    localparam int C_TAG_W     = 4;
    localparam int C_ROB_IDX_W = 5;

    typedef logic [C_ADDR_W-1:0]    ADDR;
    typedef logic [C_BLOCK_W-1:0]   MEM_BLOCK;
    typedef logic [C_TAG_W-1:0]     MEM_TAG;
    typedef logic [C_ROB_IDX_W-1:0] ROB_IDX;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_COMMAND;

    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic     valid;
        ADDR      addr;
        MEM_BLOCK data;
        logic [7:0] mask;
        MEM_SIZE  size;
        ROB_IDX   rob_idx;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Places a right-justified store into its 64-bit block.
// Revision    : 1.0 - initial release
// ============================================================================
module store_align
    import store_drain_unit_pkg::*;
(
    input  ADDR        addr,
    input  MEM_SIZE    size,
    input  MEM_BLOCK   data,
    output ADDR        block_addr,
    output MEM_BLOCK   block_data,
    output logic [7:0] mask,
    output logic       misaligned
);

    logic [2:0] w_off;

    assign w_off      = addr[2:0];
    assign block_addr = {addr[31:3], 3'b000};
    assign block_data = data << {w_off, 3'b000};

    always_comb begin
        mask       = 8'h00;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                mask       = 8'h01 << w_off;
                misaligned = 1'b0;
            end
            HALF: begin
                mask       = 8'h03 << w_off;
                misaligned = addr[0];
            end
            WORD: begin
                mask       = 8'h0F << w_off;
                misaligned = (addr[1:0] != 2'b00);
            end
            DOUBLE: begin
                mask       = 8'hFF;
                misaligned = (addr[2:0] != 3'b000);
            end
            default: begin
                mask       = 8'h00;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_drain_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_unit
// Description : Buffers committed stores and drains them in order to memory.
// Revision    : 1.0 - initial release
// ============================================================================
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int WB_IDX_W = $clog2(WB_DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dc_req_valid,
    input  ADDR                           dc_req_addr,
    input  MEM_SIZE                       dc_req_size,
    input  MEM_COMMAND                    dc_req_cmd,
    input  MEM_BLOCK                      dc_store_data,
    input  ROB_IDX                        dc_rob_idx,
    output logic                          dc_req_accept,
    input  logic                          mem_grant_i,
    input  MEM_TAG                        mem_tag_i,
    output MEM_COMMAND                    proc2mem_command,
    output ADDR                           proc2mem_addr,
    output MEM_BLOCK                      proc2mem_data,
    output MEM_SIZE                       proc2mem_size,
    output logic [7:0]                    proc2mem_mask,
    output logic                          store_done_valid,
    output ROB_IDX                        store_done_rob_idx,
    output logic                          misaligned_o,
    output logic                          wb_empty,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count
);

    localparam int               CNT_W  = $clog2(WB_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WB_DEPTH);

    wb_entry_t           r_wb [WB_DEPTH];
    logic [WB_IDX_W-1:0] r_head;
    logic [WB_IDX_W-1:0] r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    drain_state_t        r_state;
    drain_state_t        w_state_next;
    logic                r_done_valid;
    ROB_IDX              r_done_rob;
    logic                r_misaligned;

    ADDR        w_blk_addr;
    MEM_BLOCK   w_blk_data;
    logic [7:0] w_blk_mask;
    logic       w_misaligned;
    wb_entry_t  w_new_entry;
    wb_entry_t  w_head_entry;
    logic       w_take;
    logic       w_push;
    logic       w_issue;
    logic       w_pop;

    store_align u_align (
        .addr       (dc_req_addr),
        .size       (dc_req_size),
        .data       (dc_store_data),
        .block_addr (w_blk_addr),
        .block_data (w_blk_data),
        .mask       (w_blk_mask),
        .misaligned (w_misaligned)
    );

    // Accept depends on occupancy only, so a full buffer stalls even on a pop cycle.
    assign dc_req_accept = (r_count < C_FULL);
    assign w_take        = dc_req_valid && dc_req_accept && (dc_req_cmd == MEM_STORE);
    assign w_push        = w_take && !w_misaligned;
    assign w_head_entry  = r_wb[r_head];
    assign w_issue       = (r_state == DRAIN_REQ) && w_head_entry.valid;
    assign w_pop         = w_issue && mem_grant_i && (mem_tag_i != '0);
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_new_entry         = '0;
        w_new_entry.valid   = 1'b1;
        w_new_entry.addr    = w_blk_addr;
        w_new_entry.data    = w_blk_data;
        w_new_entry.mask    = w_blk_mask;
        w_new_entry.size    = dc_req_size;
        w_new_entry.rob_idx = dc_rob_idx;
    end

    generate
        for (genvar i = 0; i < WB_DEPTH; i++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_wb[i] <= '0;
                end else if (w_push && (r_tail == WB_IDX_W'(i))) begin
                    r_wb[i] <= w_new_entry;
                end else if (w_pop && (r_head == WB_IDX_W'(i))) begin
                    r_wb[i].valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + WB_IDX_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + WB_IDX_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= DRAIN_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Looking at the next count lets a store enqueued into an empty buffer issue one cycle later.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DRAIN_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                if (w_count_next == '0) begin
                    w_state_next = DRAIN_IDLE;
                end
            end
            default: begin
                w_state_next = DRAIN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done_valid <= 1'b0;
            r_done_rob   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_done_valid <= w_pop;
            r_done_rob   <= w_pop ? w_head_entry.rob_idx : '0;
            r_misaligned <= w_take && w_misaligned;
        end
    end

    assign proc2mem_command   = w_issue ? MEM_STORE : MEM_NONE;
    assign proc2mem_addr      = w_issue ? w_head_entry.addr : '0;
    assign proc2mem_data      = w_issue ? w_head_entry.data : '0;
    assign proc2mem_mask      = w_issue ? w_head_entry.mask : 8'h00;
    assign proc2mem_size      = w_issue ? w_head_entry.size : BYTE;
    assign store_done_valid   = r_done_valid;
    assign store_done_rob_idx = r_done_rob;
    assign misaligned_o       = r_misaligned;
    assign wb_empty           = (r_count == '0);
    assign wb_count           = r_count;

endmodule
`default_nettype wire
